// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Presents a small writable program, one word at a time, to the
//   single-cycle datapath instruction input. Each word is held for
//   HOLD_CYCLES accepted cycles. Words advance only on cycles where the
//   consumer asserts instr_ready.
//
// Parameters
//   XLEN        instruction width
//   DEPTH       program buffer entries (power of two, >= 2)
//   HOLD_CYCLES accepted cycles per word (>= 1)
//   NOP_WORD    word driven while instr_valid is low
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   load_en/addr/data   program buffer write (ignored while running)
//   len                 word count, sampled on start, clamped to DEPTH
//   start, stop         sequence control; stop wins over start
//   instr_ready         consumer accepts the current word this cycle
//   instr, instr_valid  current word and its qualifier
//   pc_idx              buffer index of the current word
//   busy, done          running / completed normally
//
// Build option
//   SEQ_LOOP_EN  wrap to index 0 after the last word instead of
//                finishing; only len==0 then reaches DONE.
module instr_sequencer #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 16,
  parameter int              HOLD_CYCLES = 3,
  parameter logic [XLEN-1:0] NOP_WORD    = XLEN'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]          load_data,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     instr_ready,
  output logic [XLEN-1:0]          instr,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH)-1:0] pc_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int LW   = $clog2(DEPTH);
  localparam int LENW = LW + 1;
  localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // All registered state and outputs in one record so the next-state
  // logic can start from "hold everything" and override fields.
  typedef struct packed {
    state_t          state;
    logic [LENW-1:0] len;
    logic [HW-1:0]   hold;
    logic [LW-1:0]   pc;
    logic [XLEN-1:0] instr;
    logic            valid;
    logic            busy;
    logic            done;
  } seq_t;

  localparam seq_t RST = '{state: IDLE, len: '0, hold: '0, pc: '0,
                           instr: NOP_WORD, valid: 1'b0, busy: 1'b0,
                           done: 1'b0};

  seq_t q, d;
  logic [DEPTH-1:0][XLEN-1:0] mem;

  logic [LENW-1:0] len_clamp;
  logic [XLEN-1:0] word0;
  logic [LW-1:0]   pc_inc;
  logic            hold_last;
  logic            last_word;

  // Program buffer: not reset, frozen while a sequence is running.
  always_ff @(posedge clk) begin
    if (load_en && q.state != RUN) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST;
    else        q <= d;
  end

  always_comb begin
    len_clamp = (len > LENW'(DEPTH)) ? LENW'(DEPTH) : len;
    // A write to entry 0 on the start edge must be seen by the first word.
    word0     = (load_en && load_addr == '0) ? load_data : mem[0];
    pc_inc    = q.pc + LW'(1);
    hold_last = (q.hold == HW'(HOLD_CYCLES - 1));
    last_word = ({1'b0, q.pc} == q.len - LENW'(1));
    d = q;

    case (q.state)
      IDLE, DONE: begin
        if (stop) begin
          d.state = IDLE;
          d.done  = 1'b0;
        end else if (start) begin
          d.len  = len_clamp;
          d.hold = '0;
          d.pc   = '0;
          if (len_clamp == '0) begin
            d.state = DONE;
            d.instr = NOP_WORD;
            d.valid = 1'b0;
            d.busy  = 1'b0;
            d.done  = 1'b1;
          end else begin
            d.state = RUN;
            d.instr = word0;
            d.valid = 1'b1;
            d.busy  = 1'b1;
            d.done  = 1'b0;
          end
        end
      end

      RUN: begin
        if (stop) begin
          // pc is left where it was so the abort point stays visible.
          d.state = IDLE;
          d.hold  = '0;
          d.instr = NOP_WORD;
          d.valid = 1'b0;
          d.busy  = 1'b0;
          d.done  = 1'b0;
        end else if (instr_ready) begin
          if (hold_last) begin
            d.hold = '0;
            if (last_word) begin
`ifdef SEQ_LOOP_EN
              d.pc    = '0;
              d.instr = mem[0];
`else
              d.state = DONE;
              d.instr = NOP_WORD;
              d.valid = 1'b0;
              d.busy  = 1'b0;
              d.done  = 1'b1;
`endif
            end else begin
              d.pc    = pc_inc;
              d.instr = mem[pc_inc];
            end
          end else begin
            d.hold = q.hold + HW'(1);
          end
        end
      end

      default: d = RST;
    endcase
  end

  assign instr       = q.instr;
  assign instr_valid = q.valid;
  assign pc_idx      = q.pc;
  assign busy        = q.busy;
  assign done        = q.done;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (DEPTH=16, HOLD_CYCLES=3).
// A per-cycle vector table covers the basic 4-word run; hand sequences
// cover back-pressure, abort, len edges, load lockout and async reset.
module tb_instr_sequencer;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 16;
  localparam int          HOLD  = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk, rst_n, load_en, start, stop, instr_ready;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic [4:0]  len;
  logic [31:0] instr;
  logic        instr_valid, busy, done;
  logic [3:0]  pc_idx;

  instr_sequencer #(.XLEN(XLEN), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD),
                    .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .len(len), .start(start), .stop(stop),
    .instr_ready(instr_ready), .instr(instr), .instr_valid(instr_valid),
    .pc_idx(pc_idx), .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start, stop, rdy;
    logic [4:0]  len;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [3:0]  e_pc;
    logic        e_busy, e_done;
  } vec_t;

  localparam logic [31:0] W0 = 32'h015A04B3, W1 = 32'h00148593,
                          W2 = 32'h0E953823, W3 = 32'h0F053283;

  vec_t        tbl[15];
  logic [31:0] exp_mem[DEPTH];
  int          n_cmp = 0, n_err = 0;
  int          cnt, bad, at;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input int a, input logic [31:0] v);
    load_en = 1'b1; load_addr = 4'(a); load_data = v;
    step();
    load_en = 1'b0;
    exp_mem[a] = v;
  endtask

  function automatic vec_t mk(logic st, logic sp, logic [4:0] l,
                              logic [31:0] ei, logic ev, logic [3:0] ep,
                              logic eb, logic ed);
    vec_t v;
    v.start = st; v.stop = sp; v.rdy = 1'b1; v.len = l;
    v.e_instr = ei; v.e_valid = ev; v.e_pc = ep; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Basic run: start at edge N, each word 3 cycles, done after N+12.
    tbl[0]  = mk(1, 0, 4, W0,  1, 0, 1, 0);
    tbl[1]  = mk(0, 0, 4, W0,  1, 0, 1, 0);
    tbl[2]  = mk(0, 0, 4, W0,  1, 0, 1, 0);
    tbl[3]  = mk(0, 0, 4, W1,  1, 1, 1, 0);
    tbl[4]  = mk(0, 0, 4, W1,  1, 1, 1, 0);
    tbl[5]  = mk(0, 0, 4, W1,  1, 1, 1, 0);
    tbl[6]  = mk(0, 0, 4, W2,  1, 2, 1, 0);
    tbl[7]  = mk(0, 0, 4, W2,  1, 2, 1, 0);
    tbl[8]  = mk(0, 0, 4, W2,  1, 2, 1, 0);
    tbl[9]  = mk(0, 0, 4, W3,  1, 3, 1, 0);
    tbl[10] = mk(0, 0, 4, W3,  1, 3, 1, 0);
    tbl[11] = mk(0, 0, 4, W3,  1, 3, 1, 0);
    tbl[12] = mk(0, 0, 4, NOP, 0, 3, 0, 1);
    tbl[13] = mk(0, 0, 4, NOP, 0, 3, 0, 1);
    tbl[14] = mk(0, 1, 4, NOP, 0, 3, 0, 0);

    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    len = '0; start = 1'b0; stop = 1'b0; instr_ready = 1'b1;
    #12;
    chk("rst.instr", instr, NOP);
    chk("rst.valid", 32'(instr_valid), 0);
    chk("rst.pc",    32'(pc_idx), 0);
    chk("rst.busy",  32'(busy), 0);
    chk("rst.done",  32'(done), 0);
    rst_n = 1'b1;
    step();

    load(0, W0); load(1, W1); load(2, W2); load(3, W3);
    chk("idle.valid", 32'(instr_valid), 0);

`ifdef SEQ_LOOP_EN
    // len=2 loops mem0, mem1, mem0, ... until stop; done never rises.
    start = 1'b1; len = 5'd2;
    step();
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      if (instr !== exp_mem[(k / 3) % 2] || !instr_valid || done) bad++;
    end
    chk("loop.seq_errors", 32'(bad), 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("loop.stop_valid", 32'(instr_valid), 0);
    chk("loop.stop_done",  32'(done), 0);
`else
    for (int i = 0; i < 15; i++) begin
      start = tbl[i].start; stop = tbl[i].stop;
      instr_ready = tbl[i].rdy; len = tbl[i].len;
      step();
      chk($sformatf("tbl[%0d].instr", i), instr, tbl[i].e_instr);
      chk($sformatf("tbl[%0d].valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl[%0d].pc", i),    32'(pc_idx), 32'(tbl[i].e_pc));
      chk($sformatf("tbl[%0d].busy", i),  32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl[%0d].done", i),  32'(done), 32'(tbl[i].e_done));
    end
    start = 1'b0; stop = 1'b0;

    // Back-pressure: two stalled cycles during word 1.
    start = 1'b1; len = 5'd4; instr_ready = 1'b1;
    step();
    start = 1'b0;
    cnt = 0; at = -1;
    for (int k = 1; k <= 40 && at < 0; k++) begin
      instr_ready = !(k == 4 || k == 5);
      step();
      if (instr_valid && instr == W1) cnt++;
      if (k == 5) chk("bp.stall_pc", 32'(pc_idx), 1);
      if (done) at = k;
    end
    instr_ready = 1'b1;
    chk("bp.w1_cycles", 32'(cnt), 5);
    chk("bp.done_cycle", 32'(at), 14);
    stop = 1'b1; step(); stop = 1'b0;

    // Abort on the edge that would complete word 2.
    start = 1'b1; len = 5'd4;
    step();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    chk("abort.pre_instr", instr, W2);
    stop = 1'b1; step(); stop = 1'b0;
    chk("abort.instr", instr, NOP);
    chk("abort.valid", 32'(instr_valid), 0);
    chk("abort.busy",  32'(busy), 0);
    chk("abort.done",  32'(done), 0);
    chk("abort.pc",    32'(pc_idx), 2);
    step();
    chk("abort.idle_done", 32'(done), 0);

    // len=0 goes straight to DONE.
    start = 1'b1; len = 5'd0;
    step();
    start = 1'b0;
    chk("len0.done",  32'(done), 1);
    chk("len0.valid", 32'(instr_valid), 0);
    chk("len0.busy",  32'(busy), 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("len0.stop_done", 32'(done), 0);

    // len=31 clamps to all 16 entries.
    for (int i = 0; i < DEPTH; i++) load(i, 32'hA000_0000 + 32'(i) * 32'h0001_0101);
    start = 1'b1; len = 5'd31;
    step();
    start = 1'b0;
    cnt = 0; bad = 0; at = -1;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) step();
      if (done) begin at = k; break; end
      if (instr_valid) begin
        cnt++;
        if (k / 3 >= DEPTH || instr !== exp_mem[k / 3] || 32'(pc_idx) != k / 3) bad++;
      end
    end
    chk("len31.valid_cycles", 32'(cnt), 48);
    chk("len31.word_errors",  32'(bad), 0);
    chk("len31.done_cycle",   32'(at), 48);
    chk("len31.final_pc",     32'(pc_idx), 15);
    stop = 1'b1; step(); stop = 1'b0;

    // Writes during RUN are dropped.
    start = 1'b1; len = 5'd2;
    step();
    start = 1'b0;
    load_en = 1'b1; load_addr = 4'd1; load_data = 32'hDEAD_BEEF;
    step();
    load_en = 1'b0;
    step(); step();
    chk("runload.w1", instr, exp_mem[1]);
    step(); step(); step();
    chk("runload.done", 32'(done), 1);
    stop = 1'b1; step(); stop = 1'b0;

    // Write to entry 0 on the start edge is seen by the first word.
    load_en = 1'b1; load_addr = 4'd0; load_data = 32'hCAFE_F00D;
    start = 1'b1; len = 5'd1;
    step();
    load_en = 1'b0; start = 1'b0;
    exp_mem[0] = 32'hCAFE_F00D;
    chk("wrstart.instr", instr, 32'hCAFE_F00D);
    chk("wrstart.valid", 32'(instr_valid), 1);
    stop = 1'b1; step(); stop = 1'b0;

    // Async reset mid-run clears outputs without waiting for an edge.
    start = 1'b1; len = 5'd4;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("midrst.pre_pc", 32'(pc_idx), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.instr", instr, NOP);
    chk("midrst.valid", 32'(instr_valid), 0);
    chk("midrst.pc",    32'(pc_idx), 0);
    chk("midrst.busy",  32'(busy), 0);
    chk("midrst.done",  32'(done), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst.after_valid", 32'(instr_valid), 0);
    chk("midrst.after_done",  32'(done), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
